// File: rtl/audio_flash_streamer.sv
// audio_flash_streamer
//    Records interleaved codec frames into a word-wide flash through a simple
//    flash-manager handshake and plays them back as whole frames.
//
// Ports
//    clock, reset        rising-edge clock, synchronous active-low reset
//    ready               one-cycle pulse marking a new codec frame
//    audio_in            recorded frame, channel 0 in the LSBs
//    start_record        begin a new recording (IDLE only)
//    start_play          begin playback when at least one frame is stored
//    stop                finish any flash request in flight, then go idle
//    loop_en             wrap playback to address 0 at the end of the data
//    audio_out           playback frame, channel 0 in the LSBs
//    frame_valid         one-cycle pulse when audio_out updates
//    writemode           flash manager direction (1 = write)
//    dowrite, doread     one-cycle flash request pulses
//    wdata               flash write word (top FLASH_W bits of the sample)
//    raddr               flash read word address
//    frdata, busy        flash read data and busy from the flash manager
//    recording, playing  state indicators
//    full, overrun       sticky status flags
//    rec_length          number of words stored by the last recording
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no activity, audio_out holds its last frame
// REC_WAIT   | recording, waiting for the next codec frame
// REC_XFER   | recording, writing the latched frame one channel at a time
// PLAY_WAIT  | playing, waiting for the next codec frame slot
// PLAY_XFER  | playing, issuing a read for the current channel
// PLAY_CAP   | playing, waiting for read data of the current channel

module audio_flash_streamer #(
   parameter int CHANNELS = 2,
   parameter int SAMPLE_W = 18,
   parameter int FLASH_W  = 16,
   parameter int ADDR_W   = 23,
   parameter int DEPTH    = 2**ADDR_W
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         ready,
   input  logic [CHANNELS*SAMPLE_W-1:0] audio_in,
   input  logic                         start_record,
   input  logic                         start_play,
   input  logic                         stop,
   input  logic                         loop_en,
   output logic [CHANNELS*SAMPLE_W-1:0] audio_out,
   output logic                         frame_valid,
   output logic                         writemode,
   output logic                         dowrite,
   output logic                         doread,
   output logic [FLASH_W-1:0]           wdata,
   output logic [ADDR_W-1:0]            raddr,
   input  logic [FLASH_W-1:0]           frdata,
   input  logic                         busy,
   output logic                         recording,
   output logic                         playing,
   output logic                         full,
   output logic                         overrun,
   output logic [ADDR_W:0]              rec_length
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
   localparam logic [ADDR_W:0]  LEN_CH   = (ADDR_W+1)'(CHANNELS);
   localparam logic [ADDR_W:0]  LEN_LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W+1:0] STEP_END = (ADDR_W+2)'(CHANNELS + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      REC_WAIT  = 3'd1,
      REC_XFER  = 3'd2,
      PLAY_WAIT = 3'd3,
      PLAY_XFER = 3'd4,
      PLAY_CAP  = 3'd5
   } state_t;

   state_t                      state_q, state_d;
   logic [CH_W-1:0]             ch_q, ch_d;
   logic [CHANNELS*SAMPLE_W-1:0] frame_q, frame_cap;
   logic                        stop_pend_q;
   logic                        stop_req;
   logic                        flash_free;
   logic [FLASH_W-1:0]          wsel;
   logic [SAMPLE_W-1:0]         cap_word;
   logic [ADDR_W+1:0]           end_sum;

   logic rec_clr, play_go, latch_go, wr_go, rd_go, cap_go;
   logic full_set, ovr_set, frame_done, wrap;

   // A request pulse is visible for one cycle before the flash manager can
   // raise busy, so the pulse cycle itself never counts as "flash free".
   assign flash_free = !busy && !dowrite && !doread;
   // stop is level-sampled; remember it so a short pulse still lands once the
   // outstanding flash request drains.
   assign stop_req   = stop || stop_pend_q;

   assign recording  = (state_q == REC_WAIT) || (state_q == REC_XFER);
   assign playing    = (state_q == PLAY_WAIT) || (state_q == PLAY_XFER) ||
                       (state_q == PLAY_CAP);

   always_comb begin
      wsel      = frame_q[int'(ch_q)*SAMPLE_W + (SAMPLE_W - FLASH_W) +: FLASH_W];
      cap_word  = '0;
      cap_word[SAMPLE_W-1 -: FLASH_W] = frdata;
      frame_cap = frame_q;
      frame_cap[int'(ch_q)*SAMPLE_W +: SAMPLE_W] = cap_word;
      // start address of the following frame plus one frame of words
      end_sum   = (ADDR_W+2)'(raddr) + STEP_END;
   end

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      rec_clr    = 1'b0;
      play_go    = 1'b0;
      latch_go   = 1'b0;
      wr_go      = 1'b0;
      rd_go      = 1'b0;
      cap_go     = 1'b0;
      full_set   = 1'b0;
      ovr_set    = 1'b0;
      frame_done = 1'b0;
      wrap       = 1'b0;
      case (state_q)
         IDLE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start_record) begin
               rec_clr = 1'b1;
               state_d = REC_WAIT;
            end else if (start_play && (rec_length >= LEN_CH)) begin
               play_go = 1'b1;
               state_d = PLAY_WAIT;
            end
         end
         REC_WAIT: begin
            if (stop_req) begin
               if (flash_free) state_d = IDLE;
            end else if (ready) begin
               latch_go = 1'b1;
               ch_d     = '0;
               state_d  = REC_XFER;
            end
         end
         REC_XFER: begin
            ovr_set = ready;
            if (stop_req) begin
               if (flash_free) state_d = IDLE;
            end else if (flash_free) begin
               wr_go = 1'b1;
               if (rec_length == LEN_LAST) begin
                  full_set = 1'b1;
                  state_d  = IDLE;
               end else if (ch_q == CH_LAST) begin
                  state_d = REC_WAIT;
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end
         end
         PLAY_WAIT: begin
            if (stop_req) begin
               if (flash_free) state_d = IDLE;
            end else if (ready) begin
               ch_d    = '0;
               state_d = PLAY_XFER;
            end
         end
         PLAY_XFER: begin
            ovr_set = ready;
            if (stop_req) begin
               if (flash_free) state_d = IDLE;
            end else if (flash_free) begin
               rd_go   = 1'b1;
               state_d = PLAY_CAP;
            end
         end
         PLAY_CAP: begin
            ovr_set = ready;
            if (flash_free) begin
               if (stop_req) begin
                  // read completed but the frame is partial: discard it
                  state_d = IDLE;
               end else begin
                  cap_go = 1'b1;
                  if (ch_q == CH_LAST) begin
                     frame_done = 1'b1;
                     if (end_sum > {1'b0, rec_length}) begin
                        if (loop_en) begin
                           wrap    = 1'b1;
                           state_d = PLAY_WAIT;
                        end else begin
                           state_d = IDLE;
                        end
                     end else begin
                        state_d = PLAY_WAIT;
                     end
                  end else begin
                     ch_d    = ch_q + 1'b1;
                     state_d = PLAY_XFER;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         frame_q     <= '0;
         stop_pend_q <= 1'b0;
         writemode   <= 1'b0;
         dowrite     <= 1'b0;
         doread      <= 1'b0;
         wdata       <= '0;
         raddr       <= '0;
         audio_out   <= '0;
         frame_valid <= 1'b0;
         rec_length  <= '0;
         full        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         stop_pend_q <= stop_req && (state_q != IDLE) && (state_d != IDLE);
         dowrite     <= wr_go;
         doread      <= rd_go;
         frame_valid <= frame_done;
         if (rec_clr) begin
            rec_length <= '0;
            full       <= 1'b0;
            overrun    <= 1'b0;
            writemode  <= 1'b1;
         end
         if (play_go) begin
            writemode <= 1'b0;
            raddr     <= '0;
         end
         if (latch_go) frame_q <= audio_in;
         if (wr_go) begin
            wdata      <= wsel;
            rec_length <= rec_length + 1'b1;
         end
         if (full_set) full <= 1'b1;
         if (ovr_set) overrun <= 1'b1;
         if (cap_go) begin
            frame_q <= frame_cap;
            raddr   <= wrap ? '0 : raddr + 1'b1;
         end
         if (frame_done) audio_out <= frame_cap;
      end
   end

endmodule
